// File: rtl/multiphase_pipe.sv
// Dual-edge logic pipeline: a falling-edge operator stage feeding a
// rising-edge merge register and delay chain, with a saturating result counter.
module multiphase_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             Hold,
    output logic [WIDTH-1:0] E,
    output logic             Out_valid,
    output logic [CNT_W-1:0] Out_count
);

    logic [WIDTH-1:0] op_d;
    logic [WIDTH-1:0] d_q;
    logic             d_valid_q;

    logic [WIDTH-1:0] s_d [DEPTH];
    logic [WIDTH-1:0] s_q [DEPTH];
    logic [DEPTH-1:0] sv_d;
    logic [DEPTH-1:0] sv_q;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        op_d = '0;
        if (In_valid) begin
            case (Mode)
                2'b00:   op_d = A & B;
                2'b01:   op_d = A | B;
                2'b10:   op_d = A ^ B;
                default: op_d = ~(A & B);
            endcase
        end
    end

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            d_q       <= '0;
            d_valid_q <= 1'b0;
        end else if (!Hold) begin
            d_q       <= op_d;
            d_valid_q <= In_valid;
        end
    end

    // Index 0 is the merge register; the last index drives the outputs.
    always_comb begin
        s_d[0]  = d_valid_q ? (d_q | C) : '0;
        sv_d[0] = d_valid_q;
        for (int i = 1; i < DEPTH; i++) begin
            s_d[i]  = s_q[i-1];
            sv_d[i] = sv_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sv_d[DEPTH-1] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= '0;
            end
            sv_q  <= '0;
            cnt_q <= '0;
        end else if (!Hold) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= s_d[i];
            end
            sv_q  <= sv_d;
            cnt_q <= cnt_d;
        end
    end

    assign E         = s_q[DEPTH-1];
    assign Out_valid = sv_q[DEPTH-1];
    assign Out_count = cnt_q;

endmodule
